lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu.sv | 67 ++++++
 tb/tb_lsu.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: core pipeline stage and LSU state encodings shared by the LSU and the scheduler
package lsu_pkg;
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_e;
  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_e;
endpackage

// File: rtl/lsu.sv
// lsu: per-thread load/store unit issuing one memory read or write per instruction
module lsu
  import lsu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] core_state,
  input  logic       decoded_mem_read_enable,
  input  logic       decoded_mem_write_enable,
  input  logic [7:0] rs,
  input  logic [7:0] rt,
  output logic       mem_read_valid,
  output logic [7:0] mem_read_address,
  input  logic       mem_read_ready,
  input  logic [7:0] mem_read_data,
  output logic       mem_write_valid,
  output logic [7:0] mem_write_address,
  output logic [7:0] mem_write_data,
  input  logic       mem_write_ready,
  output logic [1:0] lsu_state,
  output logic [7:0] lsu_out
);
  lsu_state_e state_q, state_d;
  logic       is_read_q;
  logic [7:0] addr_q, data_q;
  logic       start, ack;
  assign start = enable && core_state == CORE_REQUEST && (decoded_mem_read_enable || decoded_mem_write_enable);
  assign ack = is_read_q ? mem_read_ready : mem_write_ready;
  // state register
  always_ff @(posedge clk)
    state_q <= reset ? LSU_IDLE : state_d;
  // next state: only IDLE looks at enable, so an in-flight access always completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:       state_d = start ? LSU_REQUESTING : LSU_IDLE;
      LSU_REQUESTING: state_d = LSU_WAITING;
      LSU_WAITING:    state_d = ack ? LSU_DONE : LSU_WAITING;
      LSU_DONE:       state_d = core_state == CORE_UPDATE ? LSU_IDLE : LSU_DONE;
      default:        state_d = LSU_IDLE;
    endcase
  end
  // latch the request once, capture load data; read wins when both enables are set
  always_ff @(posedge clk) begin
    if (reset) begin
      is_read_q <= 1'b0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      lsu_out   <= 8'd0;
    end else begin
      if (state_q == LSU_REQUESTING) begin
        is_read_q <= decoded_mem_read_enable;
        addr_q    <= rs;
        data_q    <= rt;
      end
      if (state_q == LSU_WAITING && is_read_q && mem_read_ready)
        lsu_out <= mem_read_data;
    end
  end
  assign mem_read_valid    = state_q == LSU_WAITING && is_read_q;
  assign mem_write_valid   = state_q == LSU_WAITING && !is_read_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = data_q;
  assign lsu_state         = state_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for the load/store unit
module tb_lsu;
  logic       clk = 1'b0;
  logic       reset, enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  int checks = 0;
  int errors = 0;
  localparam logic [2:0] C_IDLE = 3'd0, C_REQ = 3'd3, C_WAIT = 3'd4, C_EXEC = 3'd5, C_UPD = 3'd6;
  lsu dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({lsu_state, mem_read_valid, mem_write_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: state/rv/wv=%b expected 0000", {lsu_state, mem_read_valid, mem_write_valid});
    end
    checks++;
    if ({mem_read_address, mem_write_address, mem_write_data, lsu_out} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: ra/wa/wd/out=%h expected 00000000", {mem_read_address, mem_write_address, mem_write_data, lsu_out});
    end
    reset = 1'b0;
  endtask
  task automatic test_load();
    enable = 1'b1; core_state = C_REQ; rd_en = 1'b1; rs = 8'h2A; rt = 8'h00;
    step();
    checks++;
    if ({lsu_state, mem_read_valid, mem_write_valid} !== {2'd1, 2'b00}) begin
      errors++;
      $display("FAIL load_requesting: state/rv/wv=%b expected 0100", {lsu_state, mem_read_valid, mem_write_valid});
    end
    core_state = C_WAIT;
    step();
    checks++;
    if ({lsu_state, mem_read_valid, mem_write_valid, mem_read_address} !== {2'd2, 2'b10, 8'h2A}) begin
      errors++;
      $display("FAIL load_wait1: state/rv/wv/addr=%h expected %h", {lsu_state, mem_read_valid, mem_write_valid, mem_read_address}, {2'd2, 2'b10, 8'h2A});
    end
    step();
    checks++;
    if ({lsu_state, mem_read_valid, mem_read_address} !== {2'd2, 1'b1, 8'h2A}) begin
      errors++;
      $display("FAIL load_wait2: state/rv/addr=%h expected %h", {lsu_state, mem_read_valid, mem_read_address}, {2'd2, 1'b1, 8'h2A});
    end
    mem_read_ready = 1'b1; mem_read_data = 8'h5C;
    step();
    mem_read_ready = 1'b0; mem_read_data = 8'h00;
    checks++;
    if ({lsu_state, mem_read_valid, lsu_out} !== {2'd3, 1'b0, 8'h5C}) begin
      errors++;
      $display("FAIL load_done: state/rv/out=%h expected %h", {lsu_state, mem_read_valid, lsu_out}, {2'd3, 1'b0, 8'h5C});
    end
    core_state = C_EXEC;
    step();
    core_state = C_UPD;
    checks++;
    if ({lsu_state, lsu_out} !== {2'd3, 8'h5C}) begin
      errors++;
      $display("FAIL load_hold_done: state/out=%h expected %h", {lsu_state, lsu_out}, {2'd3, 8'h5C});
    end
    step();
    checks++;
    if ({lsu_state, mem_read_valid, lsu_out} !== {2'd0, 1'b0, 8'h5C}) begin
      errors++;
      $display("FAIL load_idle: state/rv/out=%h expected %h", {lsu_state, mem_read_valid, lsu_out}, {2'd0, 1'b0, 8'h5C});
    end
    core_state = C_IDLE; rd_en = 1'b0;
  endtask
  task automatic test_store();
    core_state = C_REQ; wr_en = 1'b1; rs = 8'h10; rt = 8'hA7;
    step();
    core_state = C_WAIT;
    step();
    checks++;
    if ({lsu_state, mem_read_valid, mem_write_valid, mem_write_address, mem_write_data} !== {2'd2, 2'b01, 8'h10, 8'hA7}) begin
      errors++;
      $display("FAIL store_wait1: state/rv/wv/wa/wd=%h expected %h", {lsu_state, mem_read_valid, mem_write_valid, mem_write_address, mem_write_data}, {2'd2, 2'b01, 8'h10, 8'hA7});
    end
    rs = 8'hFF; rt = 8'h00; mem_read_ready = 1'b1; mem_read_data = 8'h99;
    step();
    mem_read_ready = 1'b0;
    checks++;
    if ({lsu_state, mem_write_valid, mem_write_address, mem_write_data, lsu_out} !== {2'd2, 1'b1, 8'h10, 8'hA7, 8'h5C}) begin
      errors++;
      $display("FAIL store_hold: state/wv/wa/wd/out=%h expected %h", {lsu_state, mem_write_valid, mem_write_address, mem_write_data, lsu_out}, {2'd2, 1'b1, 8'h10, 8'hA7, 8'h5C});
    end
    mem_write_ready = 1'b1;
    step();
    mem_write_ready = 1'b0;
    checks++;
    if ({lsu_state, mem_write_valid, lsu_out} !== {2'd3, 1'b0, 8'h5C}) begin
      errors++;
      $display("FAIL store_done: state/wv/out=%h expected %h", {lsu_state, mem_write_valid, lsu_out}, {2'd3, 1'b0, 8'h5C});
    end
    core_state = C_UPD;
    step();
    core_state = C_IDLE; wr_en = 1'b0;
  endtask
  task automatic test_both();
    core_state = C_REQ; rd_en = 1'b1; wr_en = 1'b1; rs = 8'h03; rt = 8'h44;
    step();
    core_state = C_WAIT;
    step();
    checks++;
    if ({lsu_state, mem_read_valid, mem_write_valid, mem_read_address} !== {2'd2, 2'b10, 8'h03}) begin
      errors++;
      $display("FAIL both_read_wins: state/rv/wv/addr=%h expected %h", {lsu_state, mem_read_valid, mem_write_valid, mem_read_address}, {2'd2, 2'b10, 8'h03});
    end
    mem_write_ready = 1'b1;
    step();
    mem_write_ready = 1'b0;
    checks++;
    if ({lsu_state, mem_read_valid, mem_write_valid} !== {2'd2, 2'b10}) begin
      errors++;
      $display("FAIL both_ignore_wready: state/rv/wv=%b expected 1010", {lsu_state, mem_read_valid, mem_write_valid});
    end
    mem_read_ready = 1'b1; mem_read_data = 8'h11;
    step();
    mem_read_ready = 1'b0;
    checks++;
    if ({lsu_state, lsu_out} !== {2'd3, 8'h11}) begin
      errors++;
      $display("FAIL both_done: state/out=%h expected %h", {lsu_state, lsu_out}, {2'd3, 8'h11});
    end
    core_state = C_UPD;
    step();
    core_state = C_IDLE; rd_en = 1'b0; wr_en = 1'b0;
  endtask
  task automatic test_reset_mid();
    core_state = C_REQ; rd_en = 1'b1; rs = 8'h40;
    step();
    core_state = C_WAIT;
    step();
    checks++;
    if ({lsu_state, mem_read_valid} !== {2'd2, 1'b1}) begin
      errors++;
      $display("FAIL rmid_wait: state/rv=%b expected 101", {lsu_state, mem_read_valid});
    end
    reset = 1'b1; mem_read_ready = 1'b1; mem_read_data = 8'hEE;
    step();
    reset = 1'b0; mem_read_ready = 1'b0; rd_en = 1'b0; core_state = C_IDLE;
    checks++;
    if ({lsu_state, mem_read_valid, mem_read_address, lsu_out} !== {2'd0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL rmid_reset: state/rv/addr/out=%h expected %h", {lsu_state, mem_read_valid, mem_read_address, lsu_out}, {2'd0, 1'b0, 8'h00, 8'h00});
    end
    mem_read_ready = 1'b1; mem_read_data = 8'h77;
    step();
    mem_read_ready = 1'b0;
    checks++;
    if ({lsu_state, mem_read_valid, lsu_out} !== {2'd0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rmid_late_ready: state/rv/out=%h expected %h", {lsu_state, mem_read_valid, lsu_out}, {2'd0, 1'b0, 8'h00});
    end
  endtask
  task automatic test_disabled();
    enable = 1'b0; core_state = C_REQ; rd_en = 1'b1; rs = 8'h21;
    step();
    step();
    checks++;
    if ({lsu_state, mem_read_valid, mem_write_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL disabled: state/rv/wv=%b expected 0000", {lsu_state, mem_read_valid, mem_write_valid});
    end
    core_state = C_IDLE; rd_en = 1'b0;
  endtask
  task automatic test_min_latency();
    enable = 1'b1; core_state = C_REQ; wr_en = 1'b1; rs = 8'h55; rt = 8'h66;
    step();
    enable = 1'b0; core_state = C_WAIT;
    checks++;
    if (lsu_state !== 2'd1) begin
      errors++;
      $display("FAIL lat_cycle1: state=%0d expected 1", lsu_state);
    end
    step();
    checks++;
    if ({lsu_state, mem_write_valid, mem_write_address, mem_write_data} !== {2'd2, 1'b1, 8'h55, 8'h66}) begin
      errors++;
      $display("FAIL lat_cycle2: state/wv/wa/wd=%h expected %h", {lsu_state, mem_write_valid, mem_write_address, mem_write_data}, {2'd2, 1'b1, 8'h55, 8'h66});
    end
    mem_write_ready = 1'b1;
    step();
    mem_write_ready = 1'b0;
    checks++;
    if ({lsu_state, mem_write_valid} !== {2'd3, 1'b0}) begin
      errors++;
      $display("FAIL lat_cycle3: state/wv=%b expected 110", {lsu_state, mem_write_valid});
    end
    core_state = C_UPD;
    step();
    checks++;
    if (lsu_state !== 2'd0) begin
      errors++;
      $display("FAIL lat_idle: state=%0d expected 0", lsu_state);
    end
    core_state = C_IDLE; wr_en = 1'b0;
  endtask
  initial begin
    reset = 1'b1; enable = 1'b0; core_state = C_IDLE; rd_en = 1'b0; wr_en = 1'b0;
    rs = 8'h00; rt = 8'h00; mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_both();
    test_reset_mid();
    test_disabled();
    test_min_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
